fir_sync_fifo_param: RTL and testbench

//   Parametrised single-clock FIFO for FIR sample buffering inside one clock domain.

---
 rtl/fir_sync_fifo_param.sv | 153 +++++++++++++++
 tb/tb_fir_sync_fifo_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fir_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// fir_sync_fifo_param
//   Single-clock FIFO that buffers signed FIR samples between a producer
//   (e.g. ADC capture) and the FIR core input stage. Width, depth and the
//   almost-full / almost-empty thresholds are parameters. Occupancy, threshold
//   flags and sticky overflow / underflow flags are all registered.
//
// Build option
//   FIR_FIFO_FWFT_EN  undefined : standard read, dout registered, 1 clk latency
//                     defined   : first-word-fall-through, dout shows the head
//                                 word while not empty, ren acknowledges it
//
// Ports
//   clk           in   1         clock, all logic on posedge
//   rst           in   1         synchronous reset, active-high
//   wen           in   1         write request
//   din           in   WIDTH     signed write data
//   full          out  1         level == DEPTH
//   almost_full   out  1         level >= AF_THRESH
//   ren           in   1         read request (head acknowledge in FWFT)
//   dout          out  WIDTH     signed read data
//   empty         out  1         level == 0
//   almost_empty  out  1         level <= AE_THRESH
//   level         out  ADDR_W+1  occupancy 0..DEPTH
//   err_clr       in   1         clears ovf / udf
//   ovf           out  1         sticky: write attempted while full
//   udf           out  1         sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fir_sync_fifo_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int AF_THRESH = 56,
    parameter int AE_THRESH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic signed [WIDTH-1:0]  din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     ren,
    output logic signed [WIDTH-1:0]  dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDR_W:0]          level,
    input  logic                     err_clr,
    output logic                     ovf,
    output logic                     udf
);

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_AF    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0]   LP_AE    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0]   LP_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_PINC  = ADDR_W'(1);

    logic signed [WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_ovf;
    logic              r_udf;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_level_nxt;

    // Acceptance uses the registered flags only, so a same-cycle read never
    // makes room for a write when full, and a same-cycle write never feeds a
    // read when empty.
    assign w_wr_acc = wen && !r_full;
    assign w_rd_acc = ren && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + LP_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_nxt = r_level - LP_ONE;
        end
    end

    // Storage has no reset; after rst the pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and flags; all flags derive from the next level so
    // they move on the same edge as the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_ovf          <= 1'b0;
            r_udf          <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_PINC;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + LP_PINC;
            end
            r_level        <= w_level_nxt;
            r_full         <= (w_level_nxt == LP_DEPTH);
            r_empty        <= (w_level_nxt == '0);
            r_almost_full  <= (w_level_nxt >= LP_AF);
            r_almost_empty <= (w_level_nxt <= LP_AE);
            // A new error in the clearing cycle wins over err_clr.
            r_ovf          <= (wen && r_full)  || (r_ovf && !err_clr);
            r_udf          <= (ren && r_empty) || (r_udf && !err_clr);
        end
    end

`ifdef FIR_FIFO_FWFT_EN
    // Head word is visible combinationally; it is don't-care while empty.
    assign dout = r_mem[r_rd_ptr];
`else
    logic signed [WIDTH-1:0] r_dout;

    // Registered read: loads on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    assign dout = r_dout;
`endif

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign level        = r_level;
    assign ovf          = r_ovf;
    assign udf          = r_udf;

endmodule

// File: tb/tb_fir_sync_fifo_param.sv
module tb_fir_sync_fifo_param;

    localparam int W   = 16;
    localparam int D   = 64;
    localparam int AW  = 6;
    localparam int AFT = 56;
    localparam int AET = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wen;
    logic                 ren;
    logic                 err_clr;
    logic signed [W-1:0]  din;
    logic                 full;
    logic                 almost_full;
    logic signed [W-1:0]  dout;
    logic                 empty;
    logic                 almost_empty;
    logic [AW:0]          level;
    logic                 ovf;
    logic                 udf;

    int checks = 0;
    int errors = 0;

    // Scoreboard: words accepted by the FIFO, oldest first.
    logic signed [W-1:0] sb [$];
    int                  m_level = 0;
    logic                m_ovf   = 1'b0;
    logic                m_udf   = 1'b0;
    logic signed [W-1:0] m_dout  = '0;

    fir_sync_fifo_param #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .AF_THRESH(AFT), .AE_THRESH(AET)
    ) dut (
        .clk(clk), .rst(rst), .wen(wen), .din(din), .full(full),
        .almost_full(almost_full), .ren(ren), .dout(dout), .empty(empty),
        .almost_empty(almost_empty), .level(level), .err_clr(err_clr),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model, clock, then compare.
    task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                        input logic rd, input logic c);
        logic wr_acc;
        logic rd_acc;
        logic ovf_evt;
        logic udf_evt;
        rst = r; wen = w; din = d; ren = rd; err_clr = c;
        if (r) begin
            sb.delete();
            m_level = 0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_dout  = '0;
        end else begin
            wr_acc  = w && (m_level != D);
            rd_acc  = rd && (m_level != 0);
            ovf_evt = w && (m_level == D);
            udf_evt = rd && (m_level == 0);
            if (rd_acc) m_dout = sb.pop_front();
            if (wr_acc) sb.push_back(d);
            m_level = m_level + int'(wr_acc) - int'(rd_acc);
            m_ovf   = ovf_evt || (m_ovf && !c);
            m_udf   = udf_evt || (m_udf && !c);
        end
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(m_level));
        chk("full", 32'(full), 32'(m_level == D));
        chk("empty", 32'(empty), 32'(m_level == 0));
        chk("almost_full", 32'(almost_full), 32'(m_level >= AFT));
        chk("almost_empty", 32'(almost_empty), 32'(m_level <= AET));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
`ifdef FIR_FIFO_FWFT_EN
        if (m_level > 0) chk("dout_head", 32'(dout), 32'(sb[0]));
`else
        chk("dout", 32'(dout), 32'(m_dout));
`endif
        rst = 1'b0; wen = 1'b0; ren = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; err_clr = 1'b0; din = '0;

        // Reset for two clocks
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);

        // Fill 0..63
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 54) chk("af_after_55", 32'(almost_full), 32'd0);
            if (i == 55) chk("af_after_56", 32'(almost_full), 32'd1);
        end
        chk("full_after_64", 32'(full), 32'd1);
        chk("level_after_64", 32'(level), 32'd64);

        // Overflow handling and err_clr priority
        step(1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        step(1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        chk("ovf_clr_vs_err", 32'(ovf), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(ovf), 32'd0);
        // Write while full plus read: read accepted, write still dropped
        step(1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        chk("full_rw_level", 32'(level), 32'd63);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Drain
        for (int i = 0; i < D && m_level > 0; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("drained_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("udf_set", 32'(udf), 32'd1);
`ifndef FIR_FIFO_FWFT_EN
        chk("dout_hold_63", 32'(dout), 32'd63);
`endif
        // Read while empty with write: write still accepted
        step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
        chk("empty_rw_level", 32'(level), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("udf_cleared", 32'(udf), 32'd0);

        // Level 10, then simultaneous read/write across pointer wrap
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'(100 + i), 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b1, 16'(-1000 + k), 1'b1, 1'b0);
        chk("steady_level", 32'(level), 32'd10);

        // Reset mid-operation at level 30
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'(200 + i), 1'b0, 1'b0);
        chk("level_30", 32'(level), 32'd30);
        step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
`ifdef FIR_FIFO_FWFT_EN
        chk("fwft_fall_through", 32'(dout), 32'h0042);
`endif
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
`ifndef FIR_FIFO_FWFT_EN
        chk("post_rst_read", 32'(dout), 32'h0042);
`endif
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
